// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 receive front end.
// Command byte values are consumed by the LED control path downstream.
package rs485_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS = 8;

  localparam logic [7:0] CMD_WATER  = 8'h01;
  localparam logic [7:0] CMD_BREATH = 8'h02;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer plus one delay stage on the raw RO pin.
// Produces the synchronized level and a falling-edge pulse; all stages reset high.
module rx_sync_edge (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_s1_q, rx_s2_q, rx_s3_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_sync = rx_s2_q;
  assign rx_fall = rx_s3_q & ~rx_s2_q;

endmodule

// File: rtl/rs485_rx.sv
// 8N1 UART receiver for the RS485 RO pin: byte output with a one-cycle strobe,
// framing-error strobe, and start-bit glitch rejection.
module rs485_rx
  import rs485_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CW           = $clog2(BAUD_CNT_MAX);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic rx_sync, rx_fall;

  rx_sync_edge u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx      (rx),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  rx_state_e            state_q;
  logic [CW-1:0]        baud_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] po_data_q;
  logic                 po_flag_q, frame_err_q, busy_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      po_data_q   <= '0;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (rx_fall) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_cnt_q == BAUD_HALF) begin
            baud_cnt_q <= '0;
            if (!rx_sync) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            // Right shift: first (LSB) bit on the line ends up in bit 0.
            shift_q    <= {rx_sync, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            if (rx_sync) begin
              po_data_q <= shift_q;
              po_flag_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/rs485_rx.md
# rs485_rx

Serial receive front end for the RS485 link: recovers 8N1 UART frames from the transceiver's RO pin and presents each byte as `po_data` with a one-cycle `po_flag` strobe. It is the receive-direction counterpart of the LED/key control path. Its outputs feed the control logic's `pi_data` input, so the received command bytes (0x01 water-LED, 0x02 breathing-LED) select the LED mode. It also flags framing errors and rejects start-bit glitches.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `UART_BPS`, 9600: line baud rate. `BAUD_CNT_MAX = CLK_FREQ/UART_BPS` (integer division, must be ≥ 4).
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input from the transceiver RO pin; idle high.
- `po_data`  out  8  last correctly received byte, LSB first on the line.
- `po_flag`  out  1  one-cycle strobe, `po_data` valid in the same cycle.
- `frame_err`  out  1  one-cycle strobe, stop bit sampled low.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- **Input conditioning.** `rx` passes through a 2-FF synchronizer (`rx_s1`, `rx_s2`) and one delay stage (`rx_s3`). All three reset to 1. A falling edge is `rx_s3 & ~rx_s2`.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** `baud_cnt` = 0 and `bit_cnt` = 0. On a falling edge, go to START.
- **START:** `baud_cnt` increments each cycle. At `baud_cnt == BAUD_CNT_MAX/2 - 1`, check `rx_s2`:
  - 0: start bit confirmed. Clear `baud_cnt` and go to DATA.
  - 1: glitch. Return to IDLE with no output.
- **DATA:** `baud_cnt` counts 0..BAUD_CNT_MAX-1 and wraps. At `BAUD_CNT_MAX-1` (mid-bit), `rx_s2` is shifted into the MSB of `shift_reg` (right shift, so LSB-first data lands correctly) and `bit_cnt` increments. After the sample with `bit_cnt == 7`, clear `bit_cnt` and go to STOP.
- **STOP:** at `baud_cnt == BAUD_CNT_MAX-1`, sample `rx_s2` and return to IDLE:
  - 1: next cycle `po_data <= shift_reg`, `po_flag` = 1 for one cycle.
  - 0: next cycle `frame_err` = 1 for one cycle. `po_data` is unchanged and `po_flag` stays 0.
- Returning to IDLE at mid-stop-bit lets back-to-back frames be received with no idle time.
- Falling edges seen in DATA or STOP are ignored.
- `po_flag` and `frame_err` are never high in the same cycle.
- `busy` is registered and equals (state != IDLE).

## Timing
- **Reset values:** `po_data` = 0x00, `po_flag` = 0, `frame_err` = 0, `busy` = 0. The FSM is in IDLE, all counters are 0, and the synchronizer regs are 1.
- **Reset mid-frame:** the next cycle is in the reset state. The partial byte is discarded and produces no strobe.
- **Edge detect:** the edge is detected 3 cycles after `rx` falls; START is entered on the following cycle.
- **Stop sample:** taken `BAUD_CNT_MAX/2 + 9*BAUD_CNT_MAX` cycles after START entry, ±1 cycle.
- **Strobe latency:** `po_flag` rises exactly 1 cycle after the stop sample cycle.
- **Counter widths:** `baud_cnt` is `$clog2(BAUD_CNT_MAX)` bits; `bit_cnt` is 3 bits. No overflow is reachable.
- **Throughput:** one byte per 10 bit times (maximum).

## Structure
- **Package `rs485_pkg`:**
  - FSM state typedef (2-bit enum: IDLE, START, DATA, STOP).
  - Frame constants: `DATA_BITS` = 8.
  - Command byte constants: `CMD_WATER` = 8'h01, `CMD_BREATH` = 8'h02.
- **Sub-module `rx_sync_edge`:** a natural single sub-module holding the 2-FF synchronizer, delay stage and falling-edge detect. Its outputs are `rx_sync` and `rx_fall`.
- The FSM, counters and shift register stay in `rs485_rx`.

## Test plan
All scenarios use `CLK_FREQ` = 160, `UART_BPS` = 10, giving `BAUD_CNT_MAX` = 16.
- **Single byte:** drive frame 0x01 (start, 1,0,0,0,0,0,0,0, stop). Required: `po_data` = 0x01, `po_flag` high for exactly 1 cycle, 1 cycle after the stop sample; `frame_err` = 0.
- **Back-to-back:** send 0x55 then 0xAA with no idle gap. Required: two `po_flag` pulses 160 ±1 cycles apart, carrying 0x55 then 0xAA; `busy` returns low only briefly between frames.
- **Glitch reject:** hold `rx` low for 3 cycles, then high. Required: `busy` pulses, then IDLE; no `po_flag`, no `frame_err`, and `po_data` keeps its prior value.
- **Framing error:** send 0x02 with the stop bit driven low. Required: `frame_err` high for 1 cycle, `po_flag` stays 0, `po_data` unchanged from 0x00. A following valid 0x02 gives `po_data` = 0x02.
- **Reset mid-frame:** assert `sys_rst` for 1 cycle during data bit 4 of frame 0xF0. Required: all outputs return to reset values with no strobe. A subsequent 0x3C is received correctly.
- **Reset values:** immediately after reset with `rx` held high. Required: `po_data` = 0x00 and `po_flag`, `frame_err`, `busy` all 0 for 100 cycles.
